// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: func codes, FSM states,
// response flag layout and the command payload carried through the FIFO.
package alu_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned FLAG_W = 4;

    localparam logic [FUNC_W-1:0] ADD = 3'b000;
    localparam logic [FUNC_W-1:0] SUB = 3'b001;
    localparam logic [FUNC_W-1:0] NOT = 3'b010;
    localparam logic [FUNC_W-1:0] AND = 3'b011;
    localparam logic [FUNC_W-1:0] OR  = 3'b100;
    localparam logic [FUNC_W-1:0] XOR = 3'b101;
    localparam logic [FUNC_W-1:0] LT  = 3'b110;
    localparam logic [FUNC_W-1:0] EQ  = 3'b111;

    localparam int unsigned FLG_OVF   = 3;
    localparam int unsigned FLG_CARRY = 2;
    localparam int unsigned FLG_ZERO  = 1;
    localparam int unsigned FLG_OUT   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [FUNC_W-1:0] func;
    } cmd_t;

    typedef struct packed {
        logic [OPND_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } rsp_t;

    // Keep only the flags that carry meaning for the op; the ALU zero tracks
    // the adder, so logic ops recompute zero from their own result.
    function automatic rsp_t mask_rsp(input logic [FUNC_W-1:0] func,
                                      input logic [OPND_W-1:0] result,
                                      input logic ovf,
                                      input logic carry,
                                      input logic zero,
                                      input logic out);
        rsp_t r;
        r.result = result;
        r.flags  = '0;
        case (func)
            ADD, SUB: begin
                r.flags[FLG_OVF]   = ovf;
                r.flags[FLG_CARRY] = carry;
                r.flags[FLG_ZERO]  = zero;
            end
            LT, EQ: begin
                r.result         = '0;
                r.flags[FLG_OUT] = out;
            end
            default: r.flags[FLG_ZERO] = (result == OPND_W'(0));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-side and response signals of the issue stage, with the stage's
// view (slave) and its environment's view (master).
interface alu_issue_stage_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [2:0]       cmd_func;

    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_func;
    logic [3:0]       alu_result;
    logic             alu_overflow;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_result;
    logic [3:0]       rsp_flags;
    logic [2:0]       rsp_func;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_func,
        input  alu_result, alu_overflow, alu_carry, alu_zero, alu_out,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_func,
        output rsp_valid, rsp_result, rsp_flags, rsp_func, op_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_func,
        output alu_result, alu_overflow, alu_carry, alu_zero, alu_out,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_func,
        input  rsp_valid, rsp_result, rsp_flags, rsp_func, op_count
    );
endinterface

// File: rtl/alu_issue_stage_cmd_fifo.sv
// Command FIFO: DEPTH entries of cmd_t, registered full/empty, head visible
// combinationally so a pop can load the ALU operand registers directly.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t head_c,
    output logic full,
    output logic empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic [OCC_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + OCC_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - OCC_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == OCC_W'(DEPTH));
            empty <= (count_nxt == OCC_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around the external 4-bit ALU: queues commands, drives registered
// operands, captures and masks the ALU outputs into a valid/ready response.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);
    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_in;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              capture;
    logic              done;
    rsp_t              masked;

    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_func;
    logic              rsp_valid;
    logic [3:0]        rsp_result;
    logic [3:0]        rsp_flags;
    logic [2:0]        rsp_func;
    logic [CNT_W-1:0]  op_count;

    always_comb begin
        cmd_in.a    = bus.cmd_a;
        cmd_in.b    = bus.cmd_b;
        cmd_in.func = bus.cmd_func;
    end

    assign push = bus.cmd_valid && !fifo_full;

    cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wdata  (cmd_in),
        .pop    (pop),
        .head_c (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = fifo_empty ? IDLE : EXEC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: pop = !fifo_empty;
            EXEC: capture = 1'b1;
            RESP: begin
                done = bus.rsp_ready;
                pop  = bus.rsp_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    assign masked = mask_rsp(alu_func, bus.alu_result, bus.alu_overflow,
                             bus.alu_carry, bus.alu_zero, bus.alu_out);

    // Operands only change on a pop so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_func   <= '0;
            op_count   <= '0;
        end else begin
            if (pop) begin
                alu_a    <= head.a;
                alu_b    <= head.b;
                alu_func <= head.func;
            end
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= masked.result;
                rsp_flags  <= masked.flags;
                rsp_func   <= alu_func;
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
            if (done) op_count <= op_count + CNT_W'(1);
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_func   = alu_func;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_flags  = rsp_flags;
    assign bus.rsp_func   = rsp_func;
    assign bus.op_count   = op_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: closes the loop with a behavioural ALU, runs a
// directed vector table, capacity/reset sequences and random traffic.
module tb_alu_issue_stage;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NVEC  = 13;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] func;
        logic [3:0] result;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        logic [3:0] result;
        logic [3:0] flags;
        logic [2:0] func;
    } exp_t;

    typedef struct packed {
        logic [3:0] r;
        logic       ovf;
        logic       c;
        logic       z;
        logic       o;
    } alu_o_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.CNT_W(CNT_W)) bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the external ALU; its zero flag follows the adder.
    function automatic alu_o_t alu_model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] f);
        alu_o_t o;
        logic [4:0] sum;
        logic [4:0] diff;
        logic [4:0] add;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} + {1'b0, ~b} + 5'd1;
        add  = (f == 3'b001) ? diff : sum;
        case (f)
            3'b000:  o.r = sum[3:0];
            3'b001:  o.r = diff[3:0];
            3'b010:  o.r = ~a;
            3'b011:  o.r = a & b;
            3'b100:  o.r = a | b;
            3'b101:  o.r = a ^ b;
            default: o.r = add[3:0];
        endcase
        o.c   = add[4];
        o.z   = (add[3:0] == 4'd0);
        o.ovf = (f == 3'b001) ? ((a[3] != b[3]) && (diff[3] != a[3]))
                              : ((a[3] == b[3]) && (sum[3] != a[3]));
        o.o   = (f == 3'b111) ? (a == b) : ($signed(a) < $signed(b));
        return o;
    endfunction

    alu_o_t alu_o;
    assign alu_o            = alu_model(bus.alu_a, bus.alu_b, bus.alu_func);
    assign bus.alu_result   = alu_o.r;
    assign bus.alu_overflow = alu_o.ovf;
    assign bus.alu_carry    = alu_o.c;
    assign bus.alu_zero     = alu_o.z;
    assign bus.alu_out      = alu_o.o;

    // Expected response straight from the op definitions, using integer arithmetic.
    function automatic exp_t ref_model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] f);
        exp_t e;
        int sa, sb, ua, ub, s;
        logic ovf, carry, zero, out;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        ovf = 1'b0; carry = 1'b0; zero = 1'b0; out = 1'b0;
        e.func   = f;
        e.result = 4'd0;
        case (f)
            3'b000: begin
                s = sa + sb; e.result = 4'(s);
                ovf = (s > 7) || (s < -8); carry = (ua + ub) > 15;
            end
            3'b001: begin
                s = sa - sb; e.result = 4'(s);
                ovf = (s > 7) || (s < -8); carry = (ua >= ub);
            end
            3'b010: e.result = ~a;
            3'b011: e.result = a & b;
            3'b100: e.result = a | b;
            3'b101: e.result = a ^ b;
            3'b110: out = (sa < sb);
            default: out = (a == b);
        endcase
        if (f <= 3'b101) zero = (e.result == 4'd0);
        e.flags = {ovf, carry, zero, out};
        return e;
    endfunction

    int unsigned      checks = 0;
    int unsigned      failures = 0;
    int unsigned      tick_no = 0;
    int unsigned      accepted = 0;
    logic             last_cmd_hs = 1'b0;
    logic             prev_hold = 1'b0;
    logic [10:0]      held = '0;
    logic [CNT_W-1:0] exp_count = '0;
    logic [CNT_W-1:0] base_count;
    exp_t             sb[$];
    int unsigned      rsp_ticks[$];
    vec_t             vecs[NVEC];
    int unsigned      acc0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Samples at the falling edge what the next rising edge will commit.
    task automatic monitor();
        exp_t e;
        tick_no++;
        last_cmd_hs = 1'b0;
        if (!rst_n) begin
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold)
            chk("rsp_stable", {21'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_func}, {21'd0, held});
        prev_hold = bus.rsp_valid && !bus.rsp_ready;
        held      = {bus.rsp_result, bus.rsp_flags, bus.rsp_func};
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", 32'(bus.rsp_result), 32'(e.result));
                chk("sb_flags", 32'(bus.rsp_flags), 32'(e.flags));
                chk("sb_func", 32'(bus.rsp_func), 32'(e.func));
            end
            chk("sb_op_count", 32'(bus.op_count), 32'(exp_count));
            exp_count = exp_count + CNT_W'(1);
            rsp_ticks.push_back(tick_no);
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
            sb.push_back(ref_model(bus.cmd_a, bus.cmd_b, bus.cmd_func));
            accepted++;
            last_cmd_hs = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cmd();
        bus.cmd_a    = 4'($urandom);
        bus.cmd_b    = 4'($urandom);
        bus.cmd_func = 3'($urandom);
    endtask

    task automatic drain(input string name);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 200 && (sb.size() != 0 || bus.rsp_valid); k++) tick();
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Stream commands with rsp_ready low for a fixed window.
    task automatic stream_stalled(input int unsigned n_ticks);
        bus.rsp_ready = 1'b0;
        new_cmd();
        bus.cmd_valid = 1'b1;
        for (int unsigned k = 0; k < n_ticks; k++) begin
            tick();
            if (last_cmd_hs) new_cmd();
        end
    endtask

    initial begin
        vecs[0]  = '{4'd7,    4'd1,    3'b000, 4'b1000, 4'b1000};
        vecs[1]  = '{4'd3,    4'd3,    3'b001, 4'b0000, 4'b0110};
        vecs[2]  = '{4'b1010, 4'b0101, 3'b011, 4'b0000, 4'b0010};
        vecs[3]  = '{4'b1000, 4'b0001, 3'b110, 4'b0000, 4'b0001};
        vecs[4]  = '{4'd5,    4'd5,    3'b111, 4'b0000, 4'b0001};
        vecs[5]  = '{4'd5,    4'd4,    3'b111, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 4'b0110};
        vecs[7]  = '{4'b1000, 4'b0001, 3'b001, 4'b0111, 4'b1100};
        vecs[8]  = '{4'b1111, 4'b0000, 3'b010, 4'b0000, 4'b0010};
        vecs[9]  = '{4'b0110, 4'b0011, 3'b101, 4'b0101, 4'b0000};
        vecs[10] = '{4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0010};
        vecs[11] = '{4'b0001, 4'b1000, 3'b110, 4'b0000, 4'b0000};
        vecs[12] = '{4'b1010, 4'b0100, 3'b100, 4'b1110, 4'b0000};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_func = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        chk("rst_rsp_bus", {21'd0, bus.rsp_result, bus.rsp_flags, bus.rsp_func}, 32'd0);
        chk("rst_alu_bus", {21'd0, bus.alu_a, bus.alu_b, bus.alu_func}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors: latency and masking per op.
        for (int i = 0; i < int'(NVEC); i++) begin
            bus.cmd_a = vecs[i].a; bus.cmd_b = vecs[i].b; bus.cmd_func = vecs[i].func;
            bus.cmd_valid = 1'b1;
            bus.rsp_ready = 1'b0;
            tick();
            bus.cmd_valid = 1'b0;
            chk($sformatf("vec%0d_accept", i), 32'(last_cmd_hs), 32'd1);
            chk($sformatf("vec%0d_lat0", i), 32'(bus.rsp_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d_lat1", i), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("vec%0d_alu_ops", i), {21'd0, bus.alu_a, bus.alu_b, bus.alu_func},
                {21'd0, vecs[i].a, vecs[i].b, vecs[i].func});
            tick();
            chk($sformatf("vec%0d_lat2", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'(bus.rsp_result), 32'(vecs[i].result));
            chk($sformatf("vec%0d_flags", i), 32'(bus.rsp_flags), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_func", i), 32'(bus.rsp_func), 32'(vecs[i].func));
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            chk($sformatf("vec%0d_release", i), 32'(bus.rsp_valid), 32'd0);
        end
        chk("vec_op_count", 32'(bus.op_count), NVEC);

        // Capacity with a stalled consumer: DEPTH in the FIFO plus one response.
        base_count = exp_count;
        acc0 = accepted;
        stream_stalled(12);
        chk("cap_accepted", accepted - acc0, DEPTH + 1);
        chk("cap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("cap_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        drain("cap_drain");
        chk("cap_op_count", 32'(bus.op_count), 32'(base_count) + DEPTH + 1);

        // Reset while EXEC with three commands still queued.
        stream_stalled(12);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_op_count", 32'(bus.op_count), 32'd0);
        sb.delete();
        exp_count = '0;
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_no_stale", 32'(bus.rsp_valid), 32'd0);
        end

        // 256 back-to-back ops: counter wrap, pointer wrap and 2-cycle throughput.
        rsp_ticks.delete();
        acc0 = accepted;
        bus.rsp_ready = 1'b1;
        new_cmd();
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 2000 && (accepted - acc0) < 256; k++) begin
            tick();
            if (last_cmd_hs) new_cmd();
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_accepted", accepted - acc0, 32'd256);
        drain("b2b_drain");
        chk("b2b_rsp_count", 32'(rsp_ticks.size()), 32'd256);
        if (rsp_ticks.size() == 256)
            chk("b2b_throughput", rsp_ticks[255] - rsp_ticks[0], 32'd510);
        chk("b2b_op_count_wrap", 32'(bus.op_count), 32'd0);

        // Random traffic on both handshakes.
        for (int k = 0; k < 800; k++) begin
            new_cmd();
            bus.cmd_valid = ($urandom_range(0, 9) < 6);
            bus.rsp_ready = ($urandom_range(0, 9) < 5);
            tick();
        end
        drain("rand_drain");
        chk("rand_op_count", 32'(bus.op_count), 32'(exp_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
